// File: rtl/edge_pattern_gen_if.sv
// edge_pattern_gen_if: burst request fields and generated waveform/strobe signals
interface edge_pattern_gen_if #(parameter int CNT_W = 8);
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] high_len;
    logic [CNT_W-1:0] low_len;
    logic [CNT_W-1:0] num_pulses;
    logic             out;
    logic             pos_edge;
    logic             neg_edge;
    logic             busy;
    logic             done;
    logic             err;
    modport master (
        output start, abort, high_len, low_len, num_pulses,
        input  out, pos_edge, neg_edge, busy, done, err
    );
    modport slave (
        input  start, abort, high_len, low_len, num_pulses,
        output out, pos_edge, neg_edge, busy, done, err
    );
endinterface

// File: rtl/edge_pattern_gen.sv
// edge_pattern_gen: programmable pulse-burst transmitter with registered edge strobes
module edge_pattern_gen #(parameter int CNT_W = 8) (
    input logic           clk,
    input logic           rst,
    edge_pattern_gen_if.slave bus
);
    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
    state_t state, state_n;
    logic [CNT_W-1:0] phase_cnt, phase_n, pulses_left, pulses_n, hl, hl_n, ll, ll_n;
    logic pos_n, neg_n, done_n, err_n, fields_ok;
    assign fields_ok = (|bus.high_len) && (|bus.low_len) && (|bus.num_pulses);
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            phase_cnt    <= '0;
            pulses_left  <= '0;
            hl           <= '0;
            ll           <= '0;
            bus.out      <= 1'b0;
            bus.busy     <= 1'b0;
            bus.pos_edge <= 1'b0;
            bus.neg_edge <= 1'b0;
            bus.done     <= 1'b0;
            bus.err      <= 1'b0;
        end else begin
            state        <= state_n;
            phase_cnt    <= phase_n;
            pulses_left  <= pulses_n;
            hl           <= hl_n;
            ll           <= ll_n;
            bus.out      <= state_n == HIGH;
            bus.busy     <= state_n != IDLE;
            bus.pos_edge <= pos_n;
            bus.neg_edge <= neg_n;
            bus.done     <= done_n;
            bus.err      <= err_n;
        end
    end
    always_comb begin
        state_n  = state;
        phase_n  = phase_cnt;
        pulses_n = pulses_left;
        hl_n     = hl;
        ll_n     = ll;
        pos_n    = 1'b0;
        neg_n    = 1'b0;
        done_n   = 1'b0;
        err_n    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start && !bus.abort && fields_ok) begin
                    state_n  = HIGH;
                    pos_n    = 1'b1;
                    phase_n  = bus.high_len - CNT_W'(1);
                    pulses_n = bus.num_pulses;
                    hl_n     = bus.high_len;
                    ll_n     = bus.low_len;
                end else if (bus.start && !bus.abort) begin
                    err_n = 1'b1;
                end
            end
            HIGH: begin
                if (bus.abort) begin
                    state_n = IDLE;
                    neg_n   = 1'b1;
                end else if (phase_cnt == '0) begin
                    state_n = LOW;
                    neg_n   = 1'b1;
                    phase_n = ll - CNT_W'(1);
                end else begin
                    phase_n = phase_cnt - CNT_W'(1);
                end
            end
            LOW: begin
                if (bus.abort) begin
                    state_n = IDLE;
                end else if (phase_cnt == '0 && pulses_left == CNT_W'(1)) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end else if (phase_cnt == '0) begin
                    state_n  = HIGH;
                    pos_n    = 1'b1;
                    pulses_n = pulses_left - CNT_W'(1);
                    phase_n  = hl - CNT_W'(1);
                end else begin
                    phase_n = phase_cnt - CNT_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_edge_pattern_gen.sv
// tb_edge_pattern_gen: waveform-plan reference model feeding a per-cycle scoreboard
module tb_edge_pattern_gen;
    typedef struct packed {
        logic out;
        logic pos;
        logic neg;
        logic busy;
        logic done;
        logic err;
    } ent_t;
    typedef struct packed {
        logic rs;
        ent_t v;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    exp_t q[$];
    ent_t plan[$];
    ent_t last = '0;
    logic prev_out = 1'b0;

    edge_pattern_gen_if #(.CNT_W(8)) bus ();
    edge_pattern_gen #(.CNT_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    always @(negedge clk) begin
        exp_t x;
        ent_t a;
        cyc++;
        if (q.size() > 0) begin
            x = q.pop_front();
            a = '{bus.out, bus.pos_edge, bus.neg_edge, bus.busy, bus.done, bus.err};
            checks++;
            if (a !== x.v) begin
                failures++;
                $display("FAIL outputs cycle %0d: got out/pos/neg/busy/done/err=%b want %b", cyc, a, x.v);
            end
            if (!x.rs) begin
                checks++;
                if (bus.pos_edge !== (bus.out && !prev_out) || bus.neg_edge !== (!bus.out && prev_out)
                    || (bus.pos_edge && bus.neg_edge)) begin
                    failures++;
                    $display("FAIL strobe_invariant cycle %0d: got out=%b prev=%b pos=%b neg=%b", cyc,
                             bus.out, prev_out, bus.pos_edge, bus.neg_edge);
                end
            end
            prev_out = bus.out;
        end
    end

    task automatic build(input int h, input int l, input int n);
        ent_t e;
        for (int p = 0; p < n; p++) begin
            for (int i = 0; i < h; i++) begin
                e = '0; e.out = 1'b1; e.pos = (i == 0); e.busy = 1'b1;
                plan.push_back(e);
            end
            for (int i = 0; i < l; i++) begin
                e = '0; e.neg = (i == 0); e.busy = 1'b1;
                plan.push_back(e);
            end
        end
        e = '0; e.done = 1'b1;
        plan.push_back(e);
    endtask

    task automatic slot(input logic r, input logic s, input logic a,
                        input logic [7:0] h, input logic [7:0] l, input logic [7:0] n);
        ent_t e;
        @(negedge clk);
        #1;
        rst = r;
        bus.start = s;
        bus.abort = a;
        bus.high_len = h;
        bus.low_len = l;
        bus.num_pulses = n;
        e = '0;
        if (r) begin
            plan.delete();
        end else if (last.busy && a) begin
            e.neg = last.out;
            plan.delete();
        end else if (plan.size() > 0) begin
            e = plan.pop_front();
        end else if (s && !a) begin
            if (h == 0 || l == 0 || n == 0) e.err = 1'b1;
            else begin
                build(int'(h), int'(l), int'(n));
                e = plan.pop_front();
            end
        end
        last = e;
        q.push_back('{r, e});
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) slot(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    endtask

    task automatic go(input logic [7:0] h, input logic [7:0] l, input logic [7:0] n);
        slot(1'b0, 1'b1, 1'b0, h, l, n);
    endtask

    task automatic drain();
        while (plan.size() > 0) idle(1);
        idle(2);
    endtask

    initial begin
        logic r, s, a;
        logic [7:0] h, l, n;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.high_len = '0;
        bus.low_len = '0;
        bus.num_pulses = '0;
        for (int i = 0; i < 3; i++) slot(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
        idle(5);
        go(8'd2, 8'd3, 8'd2);
        drain();
        go(8'd1, 8'd1, 8'd4);
        drain();
        go(8'd5, 8'd0, 8'd5);
        idle(3);
        slot(1'b0, 1'b1, 1'b1, 8'd3, 8'd3, 8'd3);
        idle(2);
        go(8'd4, 8'd4, 8'd3);
        idle(9);
        slot(1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 8'd0);
        idle(3);
        go(8'd3, 8'd3, 8'd5);
        idle(6);
        slot(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
        idle(2);
        go(8'd3, 8'd3, 8'd2);
        drain();
        go(8'd2, 8'd1, 8'd1);
        for (int i = 0; i < 3; i++) slot(1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
        go(8'd1, 8'd2, 8'd1);
        drain();
        go(8'd255, 8'd1, 8'd1);
        drain();
        go(8'd1, 8'd255, 8'd1);
        drain();
        go(8'd1, 8'd1, 8'd255);
        drain();
        for (int i = 0; i < 2000; i++) begin
            h = ($urandom_range(0, 11) == 0) ? 8'd0 : 8'($urandom_range(1, 5));
            l = ($urandom_range(0, 11) == 0) ? 8'd0 : 8'($urandom_range(1, 5));
            n = ($urandom_range(0, 11) == 0) ? 8'd0 : 8'($urandom_range(1, 4));
            r = ($urandom_range(0, 199) == 0);
            a = ($urandom_range(0, 24) == 0);
            s = last.busy ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 2) == 0);
            slot(r, s, a, h, l, n);
        end
        drain();
        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
